obi_xbar_cfg_ctrl: RTL and testbench
====================================

Name: obi_xbar_cfg_ctrl

Overview:
- Runtime configuration controller for the OBI crossbar.
- Holds a shadow copy of the address map and per-subordinate-port default routing, programmed over a simple OBI-style register port.
- Applies a new configuration atomically: it blocks new requests at every crossbar subordinate port at a handshake boundary, waits until all outstanding transactions have drained, then commits the shadow copy to the active outputs.
- The active outputs drive the crossbar's addr_map_i, en_default_idx_i and default_idx_i.

Parameters:
- NumSbrPorts, 2: number of crossbar subordinate ports monitored and gated (1..16).
- NumMgrPorts, 2: number of crossbar manager ports; sets the index width IdxW = max(1, $clog2(NumMgrPorts)).
- NumAddrRules, 4: number of address rules (1..16).
- NumMaxTrans, 4: maximum outstanding transactions per subordinate port; sets the counter width $clog2(NumMaxTrans+1).
- TimeoutCycles, 1024: drain timeout, used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_req_i  in  1  register-port request.
- cfg_gnt_o  out  1  register-port grant (combinational).
- cfg_we_i  in  1  write enable.
- cfg_addr_i  in  12  byte address; word aligned, bits [1:0] ignored.
- cfg_wdata_i  in  32  write data.
- cfg_rvalid_o  out  1  response valid.
- cfg_rdata_o  out  32  read data.
- cfg_err_o  out  1  response error.
- mon_req_i  in  NumSbrPorts  per-port req, observed upstream of the gate.
- mon_gnt_i  in  NumSbrPorts  per-port gnt returned by the crossbar.
- mon_rvalid_i  in  NumSbrPorts  per-port rvalid from the crossbar.
- block_o  out  NumSbrPorts  gate; the integrator masks req into the crossbar and gnt out of it while set.
- busy_o  out  1  a commit is in progress.
- rule_idx_o  out  NumAddrRules*IdxW  active rule target index.
- rule_start_o  out  NumAddrRules*32  active rule start address (inclusive).
- rule_end_o  out  NumAddrRules*32  active rule end address (exclusive).
- en_default_idx_o  out  NumSbrPorts  active default enable.
- default_idx_o  out  NumSbrPorts*IdxW  active default index.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. Shadow and active tables, outstanding counters, block_o and sticky error are cleared. Reset mid-DRAIN aborts the commit with no partial update.
- Register map:
  - 0x000 CTRL: bit0 COMMIT (write 1 to start; reads 0); bit1 BUSY (read-only); bit2 TOERR (sticky, write 1 to clear).
  - 0x004 EN_DEFAULT: bits [NumSbrPorts-1:0].
  - 0x040+4p DEFAULT_IDX[p]: bits [IdxW-1:0].
  - 0x100+16r RULE[r]: +0 idx, +4 start, +8 end.
  - Unmapped addresses and +0xC: err=1, rdata=0, write ignored. Unused upper bits read 0.
- Register-port handshake:
  - Reads: cfg_gnt_o = cfg_req_i.
  - Writes: cfg_gnt_o = cfg_req_i & (state == IDLE), so writes stall during a commit.
  - cfg_rvalid_o is asserted exactly 1 cycle after each grant, with rdata and err registered.
  - One transaction per cycle; back-to-back grants are allowed.
- Outstanding counter per port:
  - +1 on mon_req&mon_gnt; -1 on mon_rvalid; both in the same cycle means no change.
  - Saturates; never wraps.
- FSM:
  - IDLE: a granted write of CTRL.COMMIT=1 goes to DRAIN on the next cycle. busy_o=1 from DRAIN entry.
  - DRAIN: block_o[p] sets in any cycle where !mon_req_i[p] | mon_gnt_i[p], so a pending request is never retracted. Once set, it stays set. When all block_o bits are 1 and all counters are 0, go to COMMIT.
  - COMMIT: 1 cycle. Active outputs load from shadow, updating visibly in the cycle after COMMIT. block_o clears and busy_o drops. Go to IDLE.
- Minimum commit latency with an idle crossbar: COMMIT write grant at cycle t, DRAIN at t+1, COMMIT at t+2, new outputs and busy_o=0 at t+3.
- Shadow writes never affect the active outputs without a commit.

Optional Feature:
- Macro: OBI_XBAR_CFG_CTRL_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in DRAIN.
  - After TimeoutCycles cycles it aborts: return to IDLE, clear block_o, set TOERR, leave the active outputs unchanged.
  - The counter resets on entry to DRAIN.
- Disabled:
  - DRAIN waits indefinitely.
  - TOERR reads 0.
  - The TimeoutCycles parameter is unused.

Decomposition:
- Shared package obi_xbar_cfg_pkg:
  - register offset constants (CtrlOffset, EnDefaultOffset, DefaultIdxBase, RuleBase, RuleStride);
  - CTRL bit positions;
  - state enum typedef {Idle, Drain, Commit}.
- Sub-module obi_xbar_cfg_drain_mon: one instance per subordinate port. It contains the outstanding counter and the block_o set logic, and outputs idle = block & (cnt == 0).

Test Plan:
- Reset, then read RULE[0].start at 0x104 -> rvalid one cycle after grant, rdata 0, err 0. All outputs 0.
- Write RULE[1] = {idx 1, start 0x1000, end 0x2000}, EN_DEFAULT=0b01, then COMMIT with no traffic -> outputs update exactly 3 cycles after the COMMIT grant; busy_o is high for 2 cycles.
- Port 0 has 2 granted requests outstanding and the commit is issued -> block_o[0] set; COMMIT is entered the cycle after the second mon_rvalid_i[0]. Tables are unchanged before that point.
- Port 1 holds mon_req_i high with no gnt at DRAIN entry -> block_o[1] stays 0 until the cycle of mon_gnt_i[1], then sets.
- Write to 0x10C and 0x800 -> err=1 and no state change. A write issued during DRAIN -> gnt held low until IDLE.
- Macro on, TimeoutCycles=8, a counter stuck at 1 -> abort after 8 DRAIN cycles: CTRL reads 0x4, outputs unchanged, block_o cleared. Writing 0x4 clears TOERR.

Source files
------------

// File: rtl/obi_xbar_cfg_pkg.sv
// Shared definitions for the OBI crossbar configuration controller.
//   - Register offsets (byte addresses) of the configuration register port.
//   - Bit positions inside the CTRL register.
//   - Commit state machine encoding.
package obi_xbar_cfg_pkg;

  localparam logic [11:0] CtrlOffset      = 12'h000;
  localparam logic [11:0] EnDefaultOffset = 12'h004;
  localparam logic [11:0] DefaultIdxBase  = 12'h040;
  localparam logic [11:0] RuleBase        = 12'h100;
  localparam logic [11:0] RuleStride      = 12'h010;

  localparam int CtrlCommitBit = 0;
  localparam int CtrlBusyBit   = 1;
  localparam int CtrlToerrBit  = 2;

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Drain  = 2'd1,
    Commit = 2'd2
  } state_e;

endpackage

// File: rtl/obi_xbar_cfg_drain_mon.sv
// Per-subordinate-port drain monitor.
// Tracks outstanding transactions on one crossbar subordinate port and owns
// that port's block gate.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   drain_i       controller is in the drain phase (gate may close)
//   clear_i       open the gate (commit finished or drain aborted)
//   req_i/gnt_i   request handshake observed at the port
//   rvalid_i      response completion observed at the port
//   block_o       registered gate
//   idle_o        gate closed and nothing outstanding after this cycle
module obi_xbar_cfg_drain_mon
  import obi_xbar_cfg_pkg::*;
#(
  parameter int NumMaxTrans = 4,
  localparam int CntW = $clog2(NumMaxTrans + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic drain_i,
  input  logic clear_i,
  input  logic req_i,
  input  logic gnt_i,
  input  logic rvalid_i,
  output logic block_o,
  output logic idle_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            block_q, block_d;
  logic            inc, dec;

  always_comb begin
    inc   = req_i & gnt_i;
    dec   = rvalid_i;
    cnt_d = cnt_q;
    // Simultaneous accept and completion cancel; both directions saturate.
    if (inc && !dec && (cnt_q != CntW'(NumMaxTrans))) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    // The gate only closes on a handshake boundary: either nothing is being
    // requested, or the pending request is being granted this very cycle.
    block_d = block_q;
    if (clear_i) begin
      block_d = 1'b0;
    end else if (drain_i && (!req_i || gnt_i)) begin
      block_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign block_o = block_q;
  // Looking at next-state values lets the controller leave DRAIN in the same
  // cycle the last gate closes or the last response returns.
  assign idle_o  = block_d & (cnt_d == '0);

endmodule

// File: rtl/obi_xbar_cfg_ctrl.sv
// Runtime configuration controller for the OBI crossbar.
// Holds a shadow address map and default routing, written through a small
// register port, and commits it atomically to the active outputs after
// gating all subordinate ports and draining outstanding transactions.
// Optional macro OBI_XBAR_CFG_CTRL_TIMEOUT_EN: abort the drain after
// TimeoutCycles cycles and flag CTRL.TOERR.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   cfg_*                           register port (req/gnt, 1-cycle rvalid)
//   mon_req_i/mon_gnt_i/mon_rvalid_i per-port traffic monitors
//   block_o                         per-port request/grant gate
//   busy_o                          commit in progress
//   rule_*_o, en_default_idx_o, default_idx_o  active crossbar configuration
module obi_xbar_cfg_ctrl
  import obi_xbar_cfg_pkg::*;
#(
  parameter int NumSbrPorts   = 2,
  parameter int NumMgrPorts   = 2,
  parameter int NumAddrRules  = 4,
  parameter int NumMaxTrans   = 4,
  parameter int TimeoutCycles = 1024,
  localparam int IdxW = (NumMgrPorts > 1) ? $clog2(NumMgrPorts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_req_i,
  output logic                           cfg_gnt_o,
  input  logic                           cfg_we_i,
  input  logic [11:0]                    cfg_addr_i,
  input  logic [31:0]                    cfg_wdata_i,
  output logic                           cfg_rvalid_o,
  output logic [31:0]                    cfg_rdata_o,
  output logic                           cfg_err_o,
  input  logic [NumSbrPorts-1:0]         mon_req_i,
  input  logic [NumSbrPorts-1:0]         mon_gnt_i,
  input  logic [NumSbrPorts-1:0]         mon_rvalid_i,
  output logic [NumSbrPorts-1:0]         block_o,
  output logic                           busy_o,
  output logic [NumAddrRules*IdxW-1:0]   rule_idx_o,
  output logic [NumAddrRules*32-1:0]     rule_start_o,
  output logic [NumAddrRules*32-1:0]     rule_end_o,
  output logic [NumSbrPorts-1:0]         en_default_idx_o,
  output logic [NumSbrPorts*IdxW-1:0]    default_idx_o
);

  state_e state_q, state_d;

  logic [NumSbrPorts-1:0]       sh_en_def_q, sh_en_def_d, act_en_def_q, act_en_def_d;
  logic [NumSbrPorts*IdxW-1:0]  sh_def_idx_q, sh_def_idx_d, act_def_idx_q, act_def_idx_d;
  logic [NumAddrRules*IdxW-1:0] sh_rule_idx_q, sh_rule_idx_d, act_rule_idx_q, act_rule_idx_d;
  logic [NumAddrRules*32-1:0]   sh_rule_start_q, sh_rule_start_d, act_rule_start_q, act_rule_start_d;
  logic [NumAddrRules*32-1:0]   sh_rule_end_q, sh_rule_end_d, act_rule_end_q, act_rule_end_d;

  logic        rvalid_q, rvalid_d, err_q, err_d, toerr_q, toerr_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] reg_addr, rd_val, rule_base;
  logic        wr_en, hit, commit_req, toerr_clr;
  logic        all_idle, abort, timeout_hit, mon_drain, mon_clear;
  logic [NumSbrPorts-1:0] mon_idle;
  logic        unused_addr_bits;

  // Writes stall while a commit is in flight so the shadow stays frozen.
  assign cfg_gnt_o = cfg_req_i & (~cfg_we_i | (state_q == Idle));
  assign wr_en     = cfg_gnt_o & cfg_we_i;
  assign reg_addr  = {20'd0, cfg_addr_i[11:2], 2'b00};
  assign unused_addr_bits = ^cfg_addr_i[1:0];

  // Register decode: read mux and shadow updates.
  always_comb begin
    rd_val          = '0;
    hit             = 1'b0;
    commit_req      = 1'b0;
    toerr_clr       = 1'b0;
    rule_base       = '0;
    sh_en_def_d     = sh_en_def_q;
    sh_def_idx_d    = sh_def_idx_q;
    sh_rule_idx_d   = sh_rule_idx_q;
    sh_rule_start_d = sh_rule_start_q;
    sh_rule_end_d   = sh_rule_end_q;

    if (reg_addr == 32'(CtrlOffset)) begin
      hit                  = 1'b1;
      rd_val[CtrlBusyBit]  = (state_q != Idle);
      rd_val[CtrlToerrBit] = toerr_q;
      if (wr_en) begin
        commit_req = cfg_wdata_i[CtrlCommitBit];
        toerr_clr  = cfg_wdata_i[CtrlToerrBit];
      end
    end

    if (reg_addr == 32'(EnDefaultOffset)) begin
      hit                        = 1'b1;
      rd_val[NumSbrPorts-1:0]    = sh_en_def_q;
      if (wr_en) sh_en_def_d     = cfg_wdata_i[NumSbrPorts-1:0];
    end

    for (int p = 0; p < NumSbrPorts; p++) begin
      if (reg_addr == 32'(DefaultIdxBase) + 32'(4 * p)) begin
        hit              = 1'b1;
        rd_val[IdxW-1:0] = sh_def_idx_q[p*IdxW +: IdxW];
        if (wr_en) sh_def_idx_d[p*IdxW +: IdxW] = cfg_wdata_i[IdxW-1:0];
      end
    end

    // Each rule occupies a 16-byte slot; the fourth word is unmapped.
    for (int r = 0; r < NumAddrRules; r++) begin
      rule_base = 32'(RuleBase) + 32'(RuleStride) * 32'(r);
      if (reg_addr == rule_base) begin
        hit              = 1'b1;
        rd_val[IdxW-1:0] = sh_rule_idx_q[r*IdxW +: IdxW];
        if (wr_en) sh_rule_idx_d[r*IdxW +: IdxW] = cfg_wdata_i[IdxW-1:0];
      end
      if (reg_addr == rule_base + 32'd4) begin
        hit    = 1'b1;
        rd_val = sh_rule_start_q[r*32 +: 32];
        if (wr_en) sh_rule_start_d[r*32 +: 32] = cfg_wdata_i;
      end
      if (reg_addr == rule_base + 32'd8) begin
        hit    = 1'b1;
        rd_val = sh_rule_end_q[r*32 +: 32];
        if (wr_en) sh_rule_end_d[r*32 +: 32] = cfg_wdata_i;
      end
    end
  end

  // Response path: one response per grant, exactly one cycle later.
  always_comb begin
    rvalid_d = cfg_gnt_o;
    err_d    = cfg_gnt_o & ~hit;
    rdata_d  = (cfg_gnt_o & ~cfg_we_i) ? rd_val : '0;
  end

`ifdef OBI_XBAR_CFG_CTRL_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;

  // Held at zero outside DRAIN, so every drain starts counting from zero.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == Drain) to_cnt_d = to_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == Drain) && (to_cnt_q == ToW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TimeoutCycles == 0);
`endif

  assign all_idle  = &mon_idle;
  assign abort     = (state_q == Drain) & ~all_idle & timeout_hit;
  assign mon_drain = (state_q == Drain);
  assign mon_clear = (state_q != Drain) | abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (commit_req) state_d = Drain;
      Drain: begin
        if (all_idle)         state_d = Commit;
        else if (timeout_hit) state_d = Idle;
      end
      Commit:  state_d = Idle;
      default: state_d = Idle;
    endcase

    toerr_d = toerr_q;
    if (toerr_clr) toerr_d = 1'b0;
    if (abort)     toerr_d = 1'b1;

    act_en_def_d     = act_en_def_q;
    act_def_idx_d    = act_def_idx_q;
    act_rule_idx_d   = act_rule_idx_q;
    act_rule_start_d = act_rule_start_q;
    act_rule_end_d   = act_rule_end_q;
    if (state_q == Commit) begin
      act_en_def_d     = sh_en_def_q;
      act_def_idx_d    = sh_def_idx_q;
      act_rule_idx_d   = sh_rule_idx_q;
      act_rule_start_d = sh_rule_start_q;
      act_rule_end_d   = sh_rule_end_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= Idle;
      sh_en_def_q      <= '0;
      sh_def_idx_q     <= '0;
      sh_rule_idx_q    <= '0;
      sh_rule_start_q  <= '0;
      sh_rule_end_q    <= '0;
      act_en_def_q     <= '0;
      act_def_idx_q    <= '0;
      act_rule_idx_q   <= '0;
      act_rule_start_q <= '0;
      act_rule_end_q   <= '0;
      rvalid_q         <= 1'b0;
      err_q            <= 1'b0;
      rdata_q          <= '0;
      toerr_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      sh_en_def_q      <= sh_en_def_d;
      sh_def_idx_q     <= sh_def_idx_d;
      sh_rule_idx_q    <= sh_rule_idx_d;
      sh_rule_start_q  <= sh_rule_start_d;
      sh_rule_end_q    <= sh_rule_end_d;
      act_en_def_q     <= act_en_def_d;
      act_def_idx_q    <= act_def_idx_d;
      act_rule_idx_q   <= act_rule_idx_d;
      act_rule_start_q <= act_rule_start_d;
      act_rule_end_q   <= act_rule_end_d;
      rvalid_q         <= rvalid_d;
      err_q            <= err_d;
      rdata_q          <= rdata_d;
      toerr_q          <= toerr_d;
    end
  end

  for (genvar gi = 0; gi < NumSbrPorts; gi++) begin : g_mon
    obi_xbar_cfg_drain_mon #(
      .NumMaxTrans (NumMaxTrans)
    ) u_mon (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .drain_i  (mon_drain),
      .clear_i  (mon_clear),
      .req_i    (mon_req_i[gi]),
      .gnt_i    (mon_gnt_i[gi]),
      .rvalid_i (mon_rvalid_i[gi]),
      .block_o  (block_o[gi]),
      .idle_o   (mon_idle[gi])
    );
  end

  assign busy_o           = (state_q != Idle);
  assign cfg_rvalid_o     = rvalid_q;
  assign cfg_rdata_o      = rdata_q;
  assign cfg_err_o        = err_q;
  assign rule_idx_o       = act_rule_idx_q;
  assign rule_start_o     = act_rule_start_q;
  assign rule_end_o       = act_rule_end_q;
  assign en_default_idx_o = act_en_def_q;
  assign default_idx_o    = act_def_idx_q;

endmodule

// File: tb/tb_obi_xbar_cfg_ctrl.sv
// Self-checking bench for obi_xbar_cfg_ctrl: directed commit/drain scenarios
// followed by randomized register traffic against a register-map model.
module tb_obi_xbar_cfg_ctrl;

  localparam int NSBR  = 2;
  localparam int NMGR  = 2;
  localparam int NRULE = 4;
  localparam int NMAX  = 4;
  localparam int TO    = 8;
  localparam int IDXW  = 1;
  localparam logic [31:0] EN_MASK  = 32'((1 << NSBR) - 1);
  localparam logic [31:0] IDX_MASK = 32'((1 << IDXW) - 1);

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    cfg_req_i, cfg_gnt_o, cfg_we_i;
  logic [11:0]             cfg_addr_i;
  logic [31:0]             cfg_wdata_i, cfg_rdata_o;
  logic                    cfg_rvalid_o, cfg_err_o;
  logic [NSBR-1:0]         mon_req_i, mon_gnt_i, mon_rvalid_i, block_o;
  logic                    busy_o;
  logic [NRULE*IDXW-1:0]   rule_idx_o;
  logic [NRULE*32-1:0]     rule_start_o, rule_end_o;
  logic [NSBR-1:0]         en_default_idx_o;
  logic [NSBR*IDXW-1:0]    default_idx_o;

  obi_xbar_cfg_ctrl #(
    .NumSbrPorts(NSBR), .NumMgrPorts(NMGR), .NumAddrRules(NRULE),
    .NumMaxTrans(NMAX), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .mon_req_i(mon_req_i), .mon_gnt_i(mon_gnt_i), .mon_rvalid_i(mon_rvalid_i),
    .block_o(block_o), .busy_o(busy_o),
    .rule_idx_o(rule_idx_o), .rule_start_o(rule_start_o), .rule_end_o(rule_end_o),
    .en_default_idx_o(en_default_idx_o), .default_idx_o(default_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: shadow and active tables as plain arrays.
  logic [31:0] sh_en, ac_en;
  logic [31:0] sh_di [NSBR];
  logic [31:0] ac_di [NSBR];
  logic [31:0] sh_rl [NRULE][3];
  logic [31:0] ac_rl [NRULE][3];
  logic        m_toerr;

  function automatic void model_reset();
    sh_en = '0; ac_en = '0; m_toerr = 1'b0;
    for (int p = 0; p < NSBR; p++) begin sh_di[p] = '0; ac_di[p] = '0; end
    for (int r = 0; r < NRULE; r++)
      for (int f = 0; f < 3; f++) begin sh_rl[r][f] = '0; ac_rl[r][f] = '0; end
  endfunction

  function automatic void model_commit();
    ac_en = sh_en;
    for (int p = 0; p < NSBR; p++) ac_di[p] = sh_di[p];
    for (int r = 0; r < NRULE; r++)
      for (int f = 0; f < 3; f++) ac_rl[r][f] = sh_rl[r][f];
  endfunction

  function automatic void model_access(input logic we, input logic [11:0] addr,
                                       input logic [31:0] wd, input logic busy,
                                       output logic [31:0] rd, output logic err);
    int off, p, r, f;
    off = int'({addr[11:2], 2'b00});
    rd  = '0;
    err = 1'b0;
    if (off == 0) begin
      rd = {29'd0, m_toerr, busy, 1'b0};
      if (we && wd[2]) m_toerr = 1'b0;
    end else if (off == 4) begin
      rd = sh_en;
      if (we) sh_en = wd & EN_MASK;
    end else if (off >= 'h40 && off < 'h40 + 4 * NSBR) begin
      p  = (off - 'h40) / 4;
      rd = sh_di[p];
      if (we) sh_di[p] = wd & IDX_MASK;
    end else if (off >= 'h100 && off < 'h100 + 16 * NRULE && (off % 16) != 12) begin
      r  = (off - 'h100) / 16;
      f  = (off % 16) / 4;
      rd = sh_rl[r][f];
      if (we) sh_rl[r][f] = (f == 0) ? (wd & IDX_MASK) : wd;
    end else begin
      err = 1'b1;
    end
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    logic [NRULE*IDXW-1:0] ridx;
    logic [NRULE*32-1:0]   rs, re;
    logic [NSBR*IDXW-1:0]  di;
    for (int r = 0; r < NRULE; r++) begin
      ridx[r*IDXW +: IDXW] = ac_rl[r][0][IDXW-1:0];
      rs[r*32 +: 32]       = ac_rl[r][1];
      re[r*32 +: 32]       = ac_rl[r][2];
    end
    for (int p = 0; p < NSBR; p++) di[p*IDXW +: IDXW] = ac_di[p][IDXW-1:0];
    check({tag, "_rule_idx"},   128'(rule_idx_o),       128'(ridx));
    check({tag, "_rule_start"}, 128'(rule_start_o),     128'(rs));
    check({tag, "_rule_end"},   128'(rule_end_o),       128'(re));
    check({tag, "_en_def"},     128'(en_default_idx_o), 128'(ac_en[NSBR-1:0]));
    check({tag, "_def_idx"},    128'(default_idx_o),    128'(di));
  endtask

  // One register-port transaction; returns in the cycle after the grant.
  task automatic xact(input string tag, input logic we, input logic [11:0] addr,
                      input logic [31:0] wd, input logic busy);
    logic [31:0] erd;
    logic        eerr;
    int          guard;
    guard = 0;
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd;
    #1;
    while (cfg_gnt_o !== 1'b1 && guard < 50) begin
      @(posedge clk_i); #2;
      guard++;
    end
    check({tag, "_gnt"}, 128'(guard < 50), 128'(1));
    model_access(we, addr, wd, busy, erd, eerr);
    @(posedge clk_i); #1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    check({tag, "_rvalid"}, 128'(cfg_rvalid_o), 128'(1));
    check({tag, "_err"},    128'(cfg_err_o),    128'(eerr));
    if (!we) check({tag, "_rdata"}, 128'(cfg_rdata_o), 128'(erd));
    $display("xact %s we=%0d addr=%03h wdata=%08h rdata=%08h err=%0d",
             tag, we, addr, wd, cfg_rdata_o, cfg_err_o);
  endtask

  // Commit with no traffic: grant at t, busy at t+1 and t+2, new outputs at t+3.
  task automatic do_commit(input string tag);
    xact({tag, "_go"}, 1'b1, 12'h000, 32'h1, 1'b0);
    check({tag, "_busy1"}, 128'(busy_o), 128'(1));
    check_outs({tag, "_old1"});
    step();
    check({tag, "_busy2"}, 128'(busy_o), 128'(1));
    check({tag, "_rvalid_once"}, 128'(cfg_rvalid_o), 128'(0));
    check({tag, "_block"}, 128'(block_o), 128'(EN_MASK[NSBR-1:0]));
    check_outs({tag, "_old2"});
    step();
    model_commit();
    check({tag, "_busy3"}, 128'(busy_o), 128'(0));
    check({tag, "_unblock"}, 128'(block_o), 128'(0));
    check_outs({tag, "_new"});
  endtask

  initial begin
    logic        we;
    logic [11:0] addr;
    int          a;

    rst_i = 1'b1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    mon_req_i = '0; mon_gnt_i = '0; mon_rvalid_i = '0;
    model_reset();
    repeat (3) step();
    rst_i = 1'b0;
    step();

    // Reset state
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_block", 128'(block_o), 128'(0));
    check("rst_rvalid", 128'(cfg_rvalid_o), 128'(0));
    check("rst_rdata", 128'(cfg_rdata_o), 128'(0));
    check("rst_err", 128'(cfg_err_o), 128'(0));
    check("rst_gnt", 128'(cfg_gnt_o), 128'(0));
    check_outs("rst");
    xact("rd_rule0_start", 1'b0, 12'h104, 32'h0, 1'b0);

    // Program rule 1 and default enable, shadow only until commit
    xact("wr_r1_idx",   1'b1, 12'h110, 32'h1, 1'b0);
    xact("wr_r1_start", 1'b1, 12'h114, 32'h1000, 1'b0);
    xact("wr_r1_end",   1'b1, 12'h118, 32'h2000, 1'b0);
    xact("wr_en_def",   1'b1, 12'h004, 32'h1, 1'b0);
    check_outs("shadow_only");
    do_commit("commit1");

    // Two outstanding on port 0 delay the commit until both complete
    mon_req_i[0] = 1'b1; mon_gnt_i[0] = 1'b1;
    step(); step();
    mon_req_i[0] = 1'b0; mon_gnt_i[0] = 1'b0;
    xact("wr_def0", 1'b1, 12'h040, 32'h1, 1'b0);
    xact("outst_go", 1'b1, 12'h000, 32'h1, 1'b0);
    check("outst_busy_t1", 128'(busy_o), 128'(1));
    step();
    check("outst_block", 128'(block_o), 128'(2'b11));
    check_outs("outst_hold");
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 12'h044; cfg_wdata_i = 32'h1;
    #1;
    check("drain_wr_gnt", 128'(cfg_gnt_o), 128'(0));
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    repeat (3) step();
    check("outst_busy_wait", 128'(busy_o), 128'(1));
    mon_rvalid_i[0] = 1'b1; step(); mon_rvalid_i[0] = 1'b0;
    step();
    check("outst_busy_one_left", 128'(busy_o), 128'(1));
    check_outs("outst_one_left");
    mon_rvalid_i[0] = 1'b1; step(); mon_rvalid_i[0] = 1'b0;
    check("outst_in_commit_busy", 128'(busy_o), 128'(1));
    check_outs("outst_in_commit");
    step();
    model_commit();
    check("outst_done_busy", 128'(busy_o), 128'(0));
    check("outst_done_block", 128'(block_o), 128'(0));
    check_outs("outst_done");

    // Port 1 has a pending request at drain entry: gate waits for its grant
    mon_req_i[1] = 1'b1;
    xact("wr_en_def2", 1'b1, 12'h004, 32'h2, 1'b0);
    xact("pend_go", 1'b1, 12'h000, 32'h1, 1'b0);
    step();
    check("pend_block_wait", 128'(block_o), 128'(2'b01));
    xact("pend_rd_ctrl", 1'b0, 12'h000, 32'h0, 1'b1);
    check("pend_block_wait2", 128'(block_o), 128'(2'b01));
    mon_gnt_i[1] = 1'b1; step(); mon_gnt_i[1] = 1'b0; mon_req_i[1] = 1'b0;
    check("pend_block_set", 128'(block_o), 128'(2'b11));
    step();
    check("pend_busy", 128'(busy_o), 128'(1));
    check_outs("pend_hold");
    mon_rvalid_i[1] = 1'b1; step(); mon_rvalid_i[1] = 1'b0;
    check("pend_commit_busy", 128'(busy_o), 128'(1));
    step();
    model_commit();
    check("pend_done_busy", 128'(busy_o), 128'(0));
    check_outs("pend_done");

    // Unmapped accesses
    xact("wr_10c", 1'b1, 12'h10C, 32'hDEADBEEF, 1'b0);
    xact("wr_800", 1'b1, 12'h800, 32'hDEADBEEF, 1'b0);
    xact("rd_10c", 1'b0, 12'h10C, 32'h0, 1'b0);
    xact("rd_r1_start", 1'b0, 12'h114, 32'h0, 1'b0);
    xact("rd_en_def", 1'b0, 12'h004, 32'h0, 1'b0);
    check_outs("after_err");

`ifdef OBI_XBAR_CFG_CTRL_TIMEOUT_EN
    // Stuck counter on port 0: drain aborts after TO cycles
    mon_req_i[0] = 1'b1; mon_gnt_i[0] = 1'b1; step();
    mon_req_i[0] = 1'b0; mon_gnt_i[0] = 1'b0;
    xact("to_wr_r2", 1'b1, 12'h124, 32'hABC, 1'b0);
    xact("to_go", 1'b1, 12'h000, 32'h1, 1'b0);
    for (int i = 0; i < TO; i++) begin
      check("to_busy", 128'(busy_o), 128'(1));
      step();
    end
    m_toerr = 1'b1;
    check("to_aborted_busy", 128'(busy_o), 128'(0));
    check("to_aborted_block", 128'(block_o), 128'(0));
    check_outs("to_aborted");
    xact("to_rd_ctrl", 1'b0, 12'h000, 32'h0, 1'b0);
    xact("to_clr", 1'b1, 12'h000, 32'h4, 1'b0);
    xact("to_rd_ctrl2", 1'b0, 12'h000, 32'h0, 1'b0);
    mon_rvalid_i[0] = 1'b1; step(); mon_rvalid_i[0] = 1'b0;
`endif

    // Randomized register traffic with periodic commits
    for (int n = 0; n < 48; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 'h004;
        1:       a = 'h40 + 4 * int'($urandom_range(0, NSBR));
        2, 3:    a = 'h100 + 16 * int'($urandom_range(0, NRULE)) + 4 * int'($urandom_range(0, 3));
        4:       a = int'($urandom_range(0, 'hFFF));
        default: a = 'h000;
      endcase
      addr = 12'(a) | 12'($urandom_range(0, 3));
      if ({addr[11:2], 2'b00} == 12'h000) we = 1'b0;
      xact("rnd", we, addr, $urandom, 1'b0);
      if (n % 16 == 15) do_commit("rnd_commit");
    end

    // Reset during DRAIN: commit abandoned, everything cleared
    mon_req_i[0] = 1'b1; mon_gnt_i[0] = 1'b1; step();
    mon_req_i[0] = 1'b0; mon_gnt_i[0] = 1'b0;
    xact("rstd_wr_r3", 1'b1, 12'h138, 32'h5555, 1'b0);
    xact("rstd_go", 1'b1, 12'h000, 32'h1, 1'b0);
    step();
    check("rstd_block", 128'(block_o[0]), 128'(1));
    rst_i = 1'b1; step(); rst_i = 1'b0;
    model_reset();
    check("rstd_busy", 128'(busy_o), 128'(0));
    check("rstd_block_clr", 128'(block_o), 128'(0));
    check_outs("rstd");
    xact("rstd_rd_r3", 1'b0, 12'h138, 32'h0, 1'b0);
    xact("rstd_wr_r0", 1'b1, 12'h108, 32'h7777, 1'b0);
    do_commit("rstd_commit");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
